// File: rtl/mem_access_unit.sv
// Load/store front-end between the execute stage and memory.
// Ports: req_* request handshake in, resp_* response handshake out,
//        mem_* address/width/enable/data to memory, mem_rdata back.

package mem_access_pkg;
    typedef enum logic [1:0] {
        write_byte = 2'd0,
        write_half = 2'd1,
        write_word = 2'd2
    } write_width_t;
endpackage

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_misalign,
    output logic            resp_illegal,
    output logic [XLEN-1:0] mem_addr,
    output write_width_t    mem_wwidth,
    output logic            mem_wenable,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int CW = (MEM_RD_LATENCY > 1) ? $clog2(MEM_RD_LATENCY) : 1;
    localparam logic [CW-1:0] WAIT_INIT = CW'(MEM_RD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t          state;
    logic            write_q;
    logic [2:0]      funct3_q;
    logic [CW-1:0]   wait_cnt;

    logic            dec_illegal;
    logic            dec_misalign;
    write_width_t    dec_width;
    logic [XLEN-1:0] dec_wdata;
    logic [XLEN-1:0] ext_rdata;

    // Gated by reset_n so the unit never advertises ready while held in reset.
    assign req_ready = (state == IDLE) && reset_n;

    // Request decode: funct3[1:0] gives the access size for loads and stores.
    always_comb begin
        dec_illegal  = req_write ? (req_funct3 > 3'b010)
                                 : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        dec_misalign = 1'b0;
        dec_width    = write_byte;
        dec_wdata    = '0;
        case (req_funct3[1:0])
            2'b00: begin
                dec_wdata = {{(XLEN-8){1'b0}}, req_wdata[7:0]};
            end
            2'b01: begin
                dec_width    = write_half;
                dec_misalign = req_addr[0];
                dec_wdata    = {{(XLEN-16){1'b0}}, req_wdata[15:0]};
            end
            2'b10: begin
                dec_width    = write_word;
                dec_misalign = |req_addr[1:0];
                dec_wdata    = req_wdata;
            end
            default: ;
        endcase
        // An illegal encoding has no meaningful size, so it never reports misalignment.
        if (dec_illegal) dec_misalign = 1'b0;
    end

    // Load data extension selected by the registered width code.
    always_comb begin
        ext_rdata = '0;
        case (funct3_q)
            3'b000:  ext_rdata = {{(XLEN-8){mem_rdata[7]}}, mem_rdata[7:0]};
            3'b001:  ext_rdata = {{(XLEN-16){mem_rdata[15]}}, mem_rdata[15:0]};
            3'b010:  ext_rdata = mem_rdata;
            3'b100:  ext_rdata = {{(XLEN-8){1'b0}}, mem_rdata[7:0]};
            3'b101:  ext_rdata = {{(XLEN-16){1'b0}}, mem_rdata[15:0]};
            default: ext_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            write_q       <= 1'b0;
            funct3_q      <= 3'b000;
            wait_cnt      <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_misalign <= 1'b0;
            resp_illegal  <= 1'b0;
            mem_addr      <= '0;
            mem_wwidth    <= write_byte;
            mem_wenable   <= 1'b0;
            mem_wdata     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        if (dec_illegal || dec_misalign) begin
                            // Faults skip memory entirely.
                            state         <= RESP;
                            resp_valid    <= 1'b1;
                            resp_rdata    <= '0;
                            resp_illegal  <= dec_illegal;
                            resp_misalign <= dec_misalign;
                        end else begin
                            state       <= ACCESS;
                            mem_addr    <= req_addr;
                            mem_wwidth  <= dec_width;
                            mem_wdata   <= dec_wdata;
                            mem_wenable <= req_write;
                        end
                    end
                end
                ACCESS: begin
                    mem_wenable <= 1'b0;
                    if (write_q) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= ext_rdata;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state         <= IDLE;
                        resp_valid    <= 1'b0;
                        resp_rdata    <= '0;
                        resp_misalign <= 1'b0;
                        resp_illegal  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases, then random
// requests checked against a byte-array reference model.

module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int LAT = 1;

    logic         clk;
    logic         reset_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [2:0]   req_funct3;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic         resp_valid;
    logic         resp_ready;
    logic [31:0]  resp_rdata;
    logic         resp_misalign;
    logic         resp_illegal;
    logic [31:0]  mem_addr;
    write_width_t mem_wwidth;
    logic         mem_wenable;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:63];
    logic [7:0] ref_mem [0:63];

    mem_access_unit #(.XLEN(32), .MEM_RD_LATENCY(LAT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .resp_illegal  (resp_illegal),
        .mem_addr      (mem_addr),
        .mem_wwidth    (mem_wwidth),
        .mem_wenable   (mem_wenable),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // Behavioural memory with one cycle of read latency.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_byte(i);
        end else begin
            if (mem_wenable) begin
                for (int i = 0; i < 4; i++) begin
                    if (i == 0 || (i == 1 && mem_wwidth != write_byte) ||
                        (i >= 2 && mem_wwidth == write_word))
                        mem[(int'(mem_addr[5:0]) + i) % 64] <= mem_wdata[8*i +: 8];
                end
            end
            mem_rdata <= {mem[(int'(mem_addr[5:0]) + 3) % 64],
                          mem[(int'(mem_addr[5:0]) + 2) % 64],
                          mem[(int'(mem_addr[5:0]) + 1) % 64],
                          mem[int'(mem_addr[5:0])]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input bit w, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] wd, input int hold);
        bit ill, mis, legal;
        int sz, exp_lat, lat, wen_cnt, guard;
        longint v;
        logic [31:0] exp_rd, exp_wd;
        write_width_t exp_ww;

        sz = 1 << f3[1:0];
        ill = w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
        mis = !ill && ((a % sz) != 0);
        legal = !ill && !mis;
        exp_lat = legal ? (w ? 2 : 2 + LAT) : 1;
        exp_ww = (sz == 1) ? write_byte : (sz == 2) ? write_half : write_word;
        exp_wd = 32'(longint'(wd) % (64'd1 << (8 * sz)));
        exp_rd = '0;
        if (legal && !w) begin
            v = 0;
            for (int i = sz - 1; i >= 0; i--) v = v * 256 + longint'(ref_mem[(a + i) % 64]);
            if (f3 < 3'd4 && sz < 4 && v >= (64'sd1 << (8 * sz - 1))) v = v - (64'sd1 << (8 * sz));
            exp_rd = v[31:0];
        end

        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_before_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;

        lat = 0;
        wen_cnt = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1 && legal) chk("mem_addr", mem_addr, a);
            if (mem_wenable) begin
                wen_cnt++;
                chk("mem_wwidth", 32'(mem_wwidth), 32'(exp_ww));
                chk("mem_wdata", mem_wdata, exp_wd);
            end
            if (resp_valid) begin
                resp_ready = (hold == 0);
                break;
            end
            resp_ready = 1'($urandom);
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("wenable_cycles", 32'(wen_cnt), (legal && w) ? 32'd1 : 32'd0);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_misalign", 32'(resp_misalign), 32'(mis));
        chk("resp_illegal", 32'(resp_illegal), 32'(ill));

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, exp_rd);
            chk("hold_misalign", 32'(resp_misalign), 32'(mis));
            chk("hold_illegal", 32'(resp_illegal), 32'(ill));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_wenable", 32'(mem_wenable), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_valid", 32'(resp_valid), 32'd0);
        chk("post_rdata", resp_rdata, 32'd0);
        chk("post_flags", {30'd0, resp_misalign, resp_illegal}, 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);

        if (legal && w)
            for (int i = 0; i < sz; i++) ref_mem[(a + i) % 64] = wd[8*i +: 8];
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_byte(i);
        reset_n = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_funct3 = 3'd0;
        req_addr = '0;
        req_wdata = '0;
        resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_flags", {30'd0, resp_misalign, resp_illegal}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wenable", 32'(mem_wenable), 32'd0);
        chk("rst_mem_wwidth", 32'(mem_wwidth), 32'(write_byte));
        reset_n = 1'b1;
        #1;
        chk("rel_req_ready", 32'(req_ready), 32'd1);

        do_req(1'b1, 3'b000, 32'h05, 32'hDEADBEEF, 0);
        do_req(1'b1, 3'b000, 32'h05, 32'h12345680, 1);
        do_req(1'b0, 3'b000, 32'h05, 32'h0, 0);
        do_req(1'b0, 3'b100, 32'h05, 32'h0, 2);
        do_req(1'b0, 3'b001, 32'h03, 32'h0, 0);
        do_req(1'b1, 3'b010, 32'h06, 32'hCAFEF00D, 0);
        do_req(1'b1, 3'b011, 32'h01, 32'h11111111, 0);
        do_req(1'b0, 3'b011, 32'h02, 32'h0, 0);
        do_req(1'b0, 3'b110, 32'h03, 32'h0, 0);
        do_req(1'b1, 3'b001, 32'h0A, 32'h9876F00D, 0);
        do_req(1'b0, 3'b001, 32'h0A, 32'h0, 0);
        do_req(1'b0, 3'b101, 32'h0A, 32'h0, 0);
        do_req(1'b1, 3'b010, 32'h10, 32'h8badf00d, 0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5);
        do_req(1'b0, 3'b010, 32'h3E, 32'h0, 0);

        // Reset during the ACCESS cycle of a store.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h20;
        req_wdata = 32'h55AA55AA;
        chk("rstmid_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid_wen_high", 32'(mem_wenable), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_wen_drop", 32'(mem_wenable), 32'd0);
        chk("rstmid_resp", 32'(resp_valid), 32'd0);
        chk("rstmid_ready_low", 32'(req_ready), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_hold_resp", 32'(resp_valid), 32'd0);
        end
        reset_n = 1'b1;
        #1;
        chk("rstmid_ready_rel", 32'(req_ready), 32'd1);
        for (int i = 0; i < 64; i++) ref_mem[i] = init_byte(i);
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_no_resp", 32'(resp_valid), 32'd0);
        end

        for (int n = 0; n < 60; n++)
            do_req(1'($urandom), 3'($urandom), 32'($urandom_range(0, 63)),
                   $urandom, int'($urandom_range(0, 3)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
